// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift sequencer:
//   - state_e   : sequencer state (IDLE / SHIFT / DONE)
//   - DIR_LEFT / DIR_RIGHT : direction encodings for in_dir
//   - STEP0 / STEP1 / STEP2 : primitive step sizes fed to shift_step_unit
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [1:0] STEP0 = 2'd0;
  localparam logic [1:0] STEP1 = 2'd1;
  localparam logic [1:0] STEP2 = 2'd2;

endpackage

// File: rtl/shift_step_unit.sv
// -----------------------------------------------------------------------------
// shift_step_unit
//   Combinational primitive: shifts a WIDTH-bit operand by 0, 1 or 2 bits.
//   Optional macro: SHIFT_SEQ_ROTATE_EN adds the rot input (rotate instead of
//   zero-fill).
// Ports:
//   d     : operand
//   step  : step size (STEP0 / STEP1 / STEP2)
//   dir   : DIR_LEFT or DIR_RIGHT
//   rot   : 1 = rotate (only with SHIFT_SEQ_ROTATE_EN)
//   q     : stepped result
// -----------------------------------------------------------------------------
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       step,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;

  always_comb begin
    shl = d << step;
    shr = d >> step;
`ifdef SHIFT_SEQ_ROTATE_EN
    // Wrap the bits pushed out back in at the other end; a zero step must
    // not wrap anything (d >> WIDTH is already zero, guard kept for clarity).
    if (rot && (step != STEP0)) begin
      shl = shl | (d >> (WIDTH - int'(step)));
      shr = shr | (d << (WIDTH - int'(step)));
    end
`endif
    q = (dir == DIR_RIGHT) ? shr : shl;
  end

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle logical shifter: performs an in_amt-bit shift as a sequence of
//   2-bit steps (the final step is 1 bit when the distance is odd).
//   Optional macro: SHIFT_SEQ_ROTATE_EN adds in_rot (rotate instead of shift).
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. in_ready is high only in IDLE; out_valid is high only in DONE
//   and out_data is held stable until the out_ready transfer.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake
//   in_data, in_amt      : operand and total shift distance
//   in_dir               : 0 = left, 1 = right
//   in_rot               : rotate request (only with SHIFT_SEQ_ROTATE_EN)
//   out_valid / out_ready: result handshake
//   out_data             : result (working register)
//   busy                 : high in SHIFT or DONE
//   dbg_state            : current FSM state
// -----------------------------------------------------------------------------
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output state_e           dbg_state
);

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] remaining;
  logic             dir_q;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q;
`endif

  logic [1:0]       step_sel;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] stepped;

  // Take a 2-bit step while at least two positions remain, else a 1-bit step.
  always_comb begin
    step_sel = STEP0;
    if (state == SHIFT) begin
      step_sel = (remaining > AMT_W'(1)) ? STEP2 : STEP1;
    end
    rem_next = remaining - AMT_W'(step_sel);
  end

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .d    (work),
    .step (step_sel),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot  (rot_q),
`endif
    .dir  (dir_q),
    .q    (stepped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      dir_q     <= DIR_LEFT;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= in_data;
            remaining <= in_amt;
            dir_q     <= in_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q     <= in_rot;
`endif
            state     <= (in_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work      <= stepped;
          remaining <= rem_next;
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
  import shift_pkg::*;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data  = '0;
  logic [AMT_W-1:0] in_amt   = '0;
  logic             in_dir   = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             in_rot   = 1'b0;
`endif
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  state_e           dbg_state;

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
`ifdef SHIFT_SEQ_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-distance result from plain arithmetic.
  function automatic logic [WIDTH-1:0] ref_result(input int d, input int amt,
                                                  input bit dir, input bit rot);
    int r;
    int k;
    if (rot) begin
      k = amt % WIDTH;
      if (dir) r = (d >> k) | (d << (WIDTH - k));
      else     r = (d << k) | (d >> (WIDTH - k));
    end else begin
      if (dir) r = d >> amt;
      else     r = d << amt;
    end
    r = r & ((1 << WIDTH) - 1);
    return WIDTH'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Issues one request, checks latency and busy, holds backpressure for
  // `hold` cycles (optionally with a competing request pending), then takes
  // the result.
  task automatic run_op(input string name, input logic [WIDTH-1:0] d,
                        input int amt, input bit dir, input bit rot,
                        input int hold, input bit pending);
    int n;
    int exp_lat;
    int busy_cnt;
    logic [WIDTH-1:0] held;
    exp_q.push_back(ref_result(int'(d), amt, dir, rot));
    exp_lat = (amt + 1) / 2;
    check({name, ".in_ready_idle"}, int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = AMT_W'(amt);
    in_dir   = dir;
`ifdef SHIFT_SEQ_ROTATE_EN
    in_rot   = rot;
`endif
    tick();  // acceptance edge
    in_valid = 1'b0;
    // Scramble request fields; they must not affect the running operation.
    in_data  = WIDTH'($urandom);
    in_amt   = AMT_W'($urandom);
    in_dir   = 1'($urandom);
`ifdef SHIFT_SEQ_ROTATE_EN
    in_rot   = 1'($urandom);
`endif
    n = 0;
    busy_cnt = 0;
    while (!out_valid && n < 16) begin
      check({name, ".state_shift"}, int'(dbg_state), int'(SHIFT));
      check({name, ".in_ready_busy"}, int'(in_ready), 0);
      busy_cnt += int'(busy);
      tick();
      n++;
    end
    check({name, ".latency"}, n, exp_lat);
    if (amt == 0) check({name, ".no_shift_state"}, int'(dbg_state), int'(DONE));
    busy_cnt += int'(busy);
    check({name, ".busy_cycles"}, busy_cnt, exp_lat + 1);
    check({name, ".out_valid"}, int'(out_valid), 1);
    held = exp_q.pop_front();
    check({name, ".out_data"}, int'(out_data), int'(held));
    // Backpressure
    if (pending) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      in_amt   = AMT_W'($urandom_range(1, 7));
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, ".hold_valid"}, int'(out_valid), 1);
      check({name, ".hold_data"}, int'(out_data), int'(held));
      check({name, ".hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();  // result transfer edge
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, ".post_valid"}, int'(out_valid), 0);
    check({name, ".post_in_ready"}, int'(in_ready), 1);
    check({name, ".post_busy"}, int'(busy), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;  // ignored during reset
    repeat (3) tick();
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.out_data", int'(out_data), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    run_op("t1_amt3_left",  4'b0001, 3, 1'b0, 1'b0, 0, 1'b0);
    run_op("t2_amt0",       4'b1011, 0, 1'b0, 1'b0, 0, 1'b0);
    run_op("t3_amt5_right", 4'b1111, 5, 1'b1, 1'b0, 0, 1'b0);
    run_op("t4_backpress",  4'b0110, 1, 1'b1, 1'b0, 4, 1'b1);
    run_op("t_amt7_left",   4'b0001, 7, 1'b0, 1'b0, 0, 1'b0);
    run_op("t_amt4_right",  4'b1000, 4, 1'b1, 1'b0, 1, 1'b0);

    // Reset mid-SHIFT on an amt=7 operation
    in_valid = 1'b1;
    in_data  = 4'b1010;
    in_amt   = 3'd7;
    in_dir   = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    in_rot   = 1'b0;
`endif
    tick();
    in_valid = 1'b0;
    tick();
    check("t5.mid_busy", int'(busy), 1);
    rst = 1'b1;
    in_valid = 1'b1;  // must be ignored while rst is high
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("t5.rst_out_valid", int'(out_valid), 0);
    check("t5.rst_out_data", int'(out_data), 0);
    check("t5.rst_in_ready", int'(in_ready), 1);
    check("t5.rst_busy", int'(busy), 0);
    run_op("t5_after_rst", 4'b0101, 1, 1'b0, 1'b0, 0, 1'b0);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("t6_rot_l1", 4'b1001, 1, 1'b0, 1'b1, 0, 1'b0);
    run_op("t6_rot_r6", 4'b1001, 6, 1'b1, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      bit r;
`ifdef SHIFT_SEQ_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      run_op("rand", WIDTH'($urandom), int'($urandom_range(0, 7)),
             1'($urandom), r, int'($urandom_range(0, 2)),
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    fails++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that performs an arbitrary-distance logical shift on a WIDTH-bit operand.
- Each cycle it issues one primitive step of 0, 1 or 2 bit positions, left or right.
- Sits between the ALU operand/control path and the shift step datapath.
- Uses a valid/ready handshake on both input and output.
- Handles one operation at a time; no overlap between operations.

Parameters:
WIDTH, 4, operand/result width in bits.
AMT_W, 3, width of requested shift amount (max distance 2^AMT_W-1).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  request present.
in_ready  output  1  block can accept a request (high only in IDLE).
in_data  input  WIDTH  operand.
in_amt  input  AMT_W  total shift distance.
in_dir  input  1  0 = left, 1 = right.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
out_data  output  WIDTH  shifted result.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock; reset is synchronous and active-high: clk, rst.
- Reset values, forced at the edge where rst is sampled high regardless of state:
  - state = IDLE
  - out_valid = 0, out_data = 0, busy = 0
  - internal remaining count = 0
- in_ready is decoded from state, so it reads 1 once state is IDLE.
- in_valid is ignored while rst is high.

States:
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data into the working register, in_amt into remaining, and in_dir.
  - If in_amt == 0, go to DONE; else go to SHIFT.
- SHIFT:
  - Step = 2 if remaining >= 2, else 1.
  - Working register <= working shifted by step in the latched direction, zero-filled.
  - remaining <= remaining - step.
  - When remaining - step == 0, go to DONE.
- DONE:
  - out_valid = 1; out_data = working register, held stable.
  - On out_ready, go to IDLE; out_valid drops on that edge.

Timing and handshake:
- Latency: request accepted at edge k → out_valid high in the cycle after edge k + ceil(amt/2). For amt = 0, out_valid is high the cycle after acceptance.
- Throughput: at most one operation per ceil(amt/2)+2 cycles.
- in_ready = 0 throughout SHIFT and DONE; in_valid asserted then is not accepted and must be held by the source.
- Outputs may be combinational from state or registered, provided the cycle behaviour above holds.

Boundary conditions:
- amt >= WIDTH: all ceil(amt/2) steps still execute; result is 0. The cycle count is data-independent.
- Maximum amt (7 at defaults): 4 SHIFT cycles, last step is 1 bit.
- Backpressure in DONE: out_data must not change while out_valid=1 and out_ready=0.
- rst asserted in SHIFT or DONE: operation is aborted and the result discarded; IDLE with in_ready=1 on the following cycle.
- in_dir and in_amt are sampled only at acceptance; later changes have no effect.

Optional Feature:
SHIFT_SEQ_ROTATE_EN
- Defined:
  - Adds input port in_rot (1 bit), latched with the request.
  - When in_rot = 1, each step rotates rather than zero-fills, so the result equals the operand rotated by amt mod WIDTH.
  - Cycle count is unchanged.
- Undefined: port in_rot is absent and all operations are logical shifts.

Decomposition:
- Package shift_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - direction constants DIR_LEFT = 0, DIR_RIGHT = 1
  - step-size localparams STEP0 / STEP1 / STEP2
- Sub-module shift_step_unit: combinational, WIDTH-bit operand, 2-bit step amount (0/1/2), dir, and rot when the feature is enabled. The sequencer instantiates one copy on the working register.

Test Plan:
1. in_data=4'b0001, amt=3, left → two SHIFT cycles (step 2, then step 1); out_data=4'b1000; out_valid in the cycle after edge k+2.
2. in_data=4'b1011, amt=0 → out_data=4'b1011, out_valid the cycle after acceptance, no SHIFT state visited.
3. in_data=4'b1111, amt=5, right → three steps (2,2,1); out_data=4'b0000; busy high for 4 cycles.
4. Hold out_ready=0 for 4 cycles in DONE with a new in_valid pending → out_data constant, in_ready=0, new request accepted only after the out_ready handshake.
5. Assert rst for 1 cycle mid-SHIFT on amt=7 → next cycle out_valid=0, out_data=0, in_ready=1; a subsequent amt=1 request completes correctly.
6. With SHIFT_SEQ_ROTATE_EN: in_data=4'b1001, amt=1, left, rot=1 → out_data=4'b0011; amt=6, right, rot=1 → out_data=4'b0110.
